// File: rtl/src_control_unit_if.sv
// rtl/src_control_unit_if.sv - SRC control unit strobe/handshake bundle.
// Optional SRC_CU_STEP_EN adds the single-step input.
interface src_control_unit_if;
  logic [4:0] opcode;
  logic       cond_met;
  logic       mem_done;
`ifdef SRC_CU_STEP_EN
  logic       step;
`endif
  logic       pc_out, pc_in, inc4;
  logic       ma_in, md_rd, md_wr, md_bus, md_out;
  logic       ir_in, c1_out, c2_out;
  logic       gra, grb, grc, r_in, r_out, ba_out;
  logic       a_in, c_in, c_out, con_in;
  logic [1:0] alu_op;
  logic       run;
  logic       illegal;
  logic [2:0] t_state;

  modport master (
`ifdef SRC_CU_STEP_EN
    input  step,
`endif
    input  opcode, cond_met, mem_done,
    output pc_out, pc_in, inc4, ma_in, md_rd, md_wr, md_bus, md_out,
    output ir_in, c1_out, c2_out, gra, grb, grc, r_in, r_out, ba_out,
    output a_in, c_in, c_out, con_in, alu_op, run, illegal, t_state
  );

  modport slave (
`ifdef SRC_CU_STEP_EN
    output step,
`endif
    output opcode, cond_met, mem_done,
    input  pc_out, pc_in, inc4, ma_in, md_rd, md_wr, md_bus, md_out,
    input  ir_in, c1_out, c2_out, gra, grb, grc, r_in, r_out, ba_out,
    input  a_in, c_in, c_out, con_in, alu_op, run, illegal, t_state
  );
endinterface

// File: rtl/src_control_unit.sv
// rtl/src_control_unit.sv - hardwired fetch/execute sequencer for the one-bus SRC.
// Optional SRC_CU_STEP_EN inserts a STEP_WAIT state after each instruction.
module src_control_unit (
  input  logic clk,
  input  logic rst,
  src_control_unit_if.master cu
);
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LD   = 5'd1;
  localparam logic [4:0] OP_LDR  = 5'd2;
  localparam logic [4:0] OP_ST   = 5'd3;
  localparam logic [4:0] OP_LA   = 5'd5;
  localparam logic [4:0] OP_BR   = 5'd8;
  localparam logic [4:0] OP_ADD  = 5'd12;
  localparam logic [4:0] OP_ADDI = 5'd13;
  localparam logic [4:0] OP_SUB  = 5'd14;
  localparam logic [4:0] OP_AND  = 5'd20;
  localparam logic [4:0] OP_OR   = 5'd22;
  localparam logic [4:0] OP_STOP = 5'd31;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
`ifdef SRC_CU_STEP_EN
    , STEP_WAIT
`endif
  } state_t;

`ifdef SRC_CU_STEP_EN
  localparam state_t DONE = STEP_WAIT;
`else
  localparam state_t DONE = T0;
`endif

  typedef struct packed {
    logic pc_out, pc_in, inc4, ma_in, md_rd, md_wr, md_bus, md_out;
    logic ir_in, c1_out, c2_out, gra, grb, grc, r_in, r_out, ba_out;
    logic a_in, c_in, c_out, con_in;
  } strobe_t;

  state_t     state, state_nxt;
  strobe_t    s;
  logic [1:0] alu;
  logic       ill;
  logic       run_i;
  logic [2:0] tst;
  logic [4:0] op;

  assign op = cu.opcode;

  always_ff @(posedge clk) begin
    if (!rst) state <= T0;
    else      state <= state_nxt;
  end

  always_comb begin
    s         = '0;
    alu       = 2'd0;
    ill       = 1'b0;
    run_i     = 1'b1;
    tst       = 3'd0;
    state_nxt = state;
    case (state)
      T0: begin
        tst = 3'd0;
        s.pc_out = 1'b1; s.ma_in = 1'b1; s.inc4 = 1'b1; s.c_in = 1'b1;
        state_nxt = T1;
      end
      T1: begin
        tst = 3'd1;
        s.c_out = 1'b1; s.pc_in = 1'b1; s.md_rd = 1'b1;
        if (cu.mem_done) state_nxt = T2;
      end
      T2: begin
        tst = 3'd2;
        s.md_out = 1'b1; s.ir_in = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        tst = 3'd3;
        state_nxt = T4;
        case (op)
          OP_NOP: state_nxt = DONE;
          OP_LD, OP_ST, OP_LA: begin
            s.grb = 1'b1; s.ba_out = 1'b1; s.a_in = 1'b1;
          end
          OP_LDR: begin
            s.pc_out = 1'b1; s.a_in = 1'b1;
          end
          OP_BR: begin
            s.grc = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR: begin
            s.grb = 1'b1; s.r_out = 1'b1; s.a_in = 1'b1;
          end
          OP_STOP: state_nxt = HALT;
          default: begin
            ill = 1'b1;
            state_nxt = DONE;
          end
        endcase
      end
      T4: begin
        tst = 3'd4;
        state_nxt = T5;
        case (op)
          OP_LD, OP_ST, OP_LA, OP_ADDI: begin
            s.c2_out = 1'b1; s.c_in = 1'b1;
          end
          OP_LDR: begin
            s.c1_out = 1'b1; s.c_in = 1'b1;
          end
          OP_BR: begin
            // branch target is written only when CON latched true
            s.grb = cu.cond_met; s.r_out = cu.cond_met; s.pc_in = cu.cond_met;
            state_nxt = DONE;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            s.grc = 1'b1; s.r_out = 1'b1; s.c_in = 1'b1;
            alu = (op == OP_SUB) ? 2'd1 : (op == OP_AND) ? 2'd2 :
                  (op == OP_OR)  ? 2'd3 : 2'd0;
          end
          default: state_nxt = DONE;
        endcase
      end
      T5: begin
        tst = 3'd5;
        state_nxt = DONE;
        case (op)
          OP_LD, OP_LDR, OP_ST: begin
            s.c_out = 1'b1; s.ma_in = 1'b1;
            state_nxt = T6;
          end
          OP_LA, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR: begin
            s.c_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
          end
          default: state_nxt = DONE;
        endcase
      end
      T6: begin
        tst = 3'd6;
        state_nxt = DONE;
        case (op)
          OP_LD, OP_LDR: begin
            s.md_rd = 1'b1;
            state_nxt = cu.mem_done ? T7 : T6;
          end
          OP_ST: begin
            s.gra = 1'b1; s.r_out = 1'b1; s.md_bus = 1'b1;
            state_nxt = T7;
          end
          default: state_nxt = DONE;
        endcase
      end
      T7: begin
        tst = 3'd7;
        state_nxt = DONE;
        case (op)
          OP_LD, OP_LDR: begin
            s.md_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
          end
          OP_ST: begin
            s.md_wr = 1'b1;
            state_nxt = cu.mem_done ? DONE : T7;
          end
          default: state_nxt = DONE;
        endcase
      end
      HALT: begin
        run_i = 1'b0;
        state_nxt = HALT;
      end
`ifdef SRC_CU_STEP_EN
      STEP_WAIT: begin
        tst = 3'd7;
        if (cu.step) state_nxt = T0;
      end
`endif
      default: state_nxt = T0;
    endcase
  end

  assign {cu.pc_out, cu.pc_in, cu.inc4, cu.ma_in, cu.md_rd, cu.md_wr, cu.md_bus,
          cu.md_out, cu.ir_in, cu.c1_out, cu.c2_out, cu.gra, cu.grb, cu.grc,
          cu.r_in, cu.r_out, cu.ba_out, cu.a_in, cu.c_in, cu.c_out,
          cu.con_in} = rst ? s : '0;
  assign cu.alu_op  = rst ? alu : 2'd0;
  assign cu.illegal = rst & ill;
  assign cu.run     = rst & run_i;
  assign cu.t_state = tst;
endmodule

// File: doc/src_control_unit.md
Name: src_control_unit

Overview:
- Hardwired sequencer for the one-bus SRC datapath.
- Runs fetch (T0-T2) and execute (T3-T7) timing steps, driving the register-transfer strobes: IR load, IR constant drive (c1/c2), PC, MA/MD, general registers (GPRs), A/C and ALU.
- Reads the 5-bit opcode from the instruction register.
- Handshakes with memory through mem_done.

Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- opcode  in  5  inst[31:27] from instruction register
- cond_met  in  1  CON flag, valid the cycle after con_in
- mem_done  in  1  memory access complete
- pc_out, pc_in, inc4  out  1 each  PC drive / PC load / C=bus+4
- ma_in, md_rd, md_wr, md_bus, md_out  out  1 each  memory-side strobes
- ir_in, c1_out, c2_out  out  1 each  IR load / drive sign-extended c1 (22b) / c2 (17b)
- gra, grb, grc, r_in, r_out, ba_out  out  1 each  register-file select and transfer
- a_in, c_in, c_out, con_in  out  1 each  A, C, CON loads / C drive
- alu_op  out  2  0=ADD 1=SUB 2=AND 3=OR
- run  out  1  high while executing
- illegal  out  1  one-cycle pulse on undefined opcode
- t_state  out  3  current step (debug)

Behaviour:
- Reset: while rst=0 at posedge, state<=T0 and halt flag cleared. All strobes, alu_op, illegal and run are 0 whenever rst=0.
- Outputs are a combinational decode of (state, opcode, cond_met). run=1 in every non-HALT state.
- Bus exclusivity: at most one of pc_out, c_out, md_out, r_out, ba_out, c1_out, c2_out is high per cycle.
- Fetch:
  - T0: pc_out, ma_in, inc4, c_in
  - T1: c_out, pc_in, md_rd
  - T2: md_out, ir_in
  - opcode is valid from T3.
- Memory wait: in any step asserting md_rd or md_wr, the state holds with strobes held while mem_done=0. It advances on the posedge where mem_done=1 (zero-wait memory gives 1 cycle/step).
- Execute, by opcode; after the last listed step go to T0:
  - nop(0):
    - T3: none
  - ld(1):
    - T3: grb, ba_out, a_in
    - T4: c2_out, ADD, c_in
    - T5: c_out, ma_in
    - T6: md_rd
    - T7: md_out, gra, r_in
  - ldr(2):
    - T3: pc_out, a_in
    - T4: c1_out, ADD, c_in
    - T5-T7: as ld
  - st(3):
    - T3-T5: as ld
    - T6: gra, r_out, md_bus
    - T7: md_wr
  - la(5):
    - T3: grb, ba_out, a_in
    - T4: c2_out, ADD, c_in
    - T5: c_out, gra, r_in
  - br(8):
    - T3: grc, r_out, con_in
    - T4: grb, r_out, pc_in only if cond_met
  - add(12)/sub(14)/and(20)/or(22):
    - T3: grb, r_out, a_in
    - T4: grc, r_out, alu_op per op, c_in
    - T5: c_out, gra, r_in
  - addi(13):
    - T3: grb, r_out, a_in
    - T4: c2_out, ADD, c_in
    - T5: c_out, gra, r_in
  - stop(31): T3 -> HALT. HALT has no strobes, run=0, and is left only by reset.
  - any other opcode: illegal=1 during T3, no strobes, T3 -> T0 (executes as nop).
- Reset mid-instruction, including during a memory wait, aborts immediately to T0. Any memory access in progress is not completed by this block.
- mem_done is ignored in states without md_rd/md_wr.

Optional Feature:
- Macro SRC_CU_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After the final execute step of each instruction the FSM enters STEP_WAIT instead of T0. STEP_WAIT has no strobes, run=1, t_state=7.
  - STEP_WAIT advances to T0 on the first posedge where step=1.
  - stop still goes to HALT.
- Undefined: no step port, no STEP_WAIT state; instructions run back-to-back.

Test Plan:
- Reset: rst=0 for 3 cycles, then 1 -> all strobes 0 during reset; first cycle after release shows T0 with pc_out=ma_in=inc4=c_in=1 and run=1.
- Fetch wait: mem_done held 0 for 4 cycles in T1 -> md_rd, c_out, pc_in held 5 cycles; T2 follows one cycle after mem_done=1.
- add (opcode 12), zero-wait memory -> 6 cycles T0-T5; T4 alu_op=0 with grc, r_out; T5 c_out, gra, r_in. sub (14) -> alu_op=1, or (22) -> alu_op=3.
- ld (1) with mem_done delayed 2 cycles in T6 -> T6 lasts 3 cycles; T7 md_out, gra, r_in; total 10 cycles with zero-wait fetch.
- br (8): cond_met=1 -> pc_in=1 in T4; cond_met=0 -> pc_in=0. Both return to T0 next cycle.
- Opcode 7 -> illegal=1 exactly one cycle at T3, then T0. Opcode 31 -> run=0 and strobes quiet for 20 cycles until rst=0. With SRC_CU_STEP_EN: no T0 until step=1.
